// File: rtl/soc_fpga_intf_jtag_master.sv
// Boot-JTAG master: shifts up to DATA_W TMS/TDI bits on a divided TCK and captures TDO.
// Optional TRSTN pulse sequencing is enabled by defining JTAG_MASTER_TRST_EN.
module soc_fpga_intf_jtag_master #(
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 6,
  parameter int CLK_DIV     = 4,
  parameter int TRST_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_jtag_en,
  input  logic              start,
  input  logic              trst_req,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] tms_vec,
  input  logic [DATA_W-1:0] tdi_vec,
  output logic [DATA_W-1:0] tdo_vec,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic              boot_jtag_tck,
  output logic              boot_jtag_tms,
  output logic              boot_jtag_tdi,
  input  logic              boot_jtag_tdo,
  output logic              boot_jtag_trstn
);

  typedef enum logic [2:0] {
    IDLE,
    TLOW,
    THIGH,
`ifdef JTAG_MASTER_TRST_EN
    TRST,
`endif
    FIN
  } state_t;

  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);

`ifdef JTAG_MASTER_TRST_EN
  localparam logic [CNT_W-1:0] TRST_LAST = CNT_W'(TRST_CYCLES - 1);
`else
  logic unused_trst;
  assign unused_trst = trst_req ^ (TRST_CYCLES == 0);
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [DATA_W-1:0] tms_q;
  logic [DATA_W-1:0] tdi_q;

  logic [LEN_W-1:0]  len_clamped;
  logic [DATA_W-1:0] tms_nxt;
  logic [DATA_W-1:0] tdi_nxt;
  logic [DATA_W-1:0] tdo_bit;

  // Latched vectors shift right so the bit on the pins is always bit 0.
  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  assign tms_nxt     = tms_q >> 1;
  assign tdi_nxt     = tdi_q >> 1;
  assign tdo_bit     = DATA_W'(boot_jtag_tdo) << idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      len_q           <= '0;
      idx             <= '0;
      tms_q           <= '0;
      tdi_q           <= '0;
      tdo_vec         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      abort           <= 1'b0;
      boot_jtag_tck   <= 1'b0;
      boot_jtag_tms   <= 1'b1;
      boot_jtag_tdi   <= 1'b0;
      boot_jtag_trstn <= 1'b1;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      // Losing the enable in any active phase parks the TAP pins and drops the request.
      if (state != IDLE && state != FIN && !boot_jtag_en) begin
        state           <= IDLE;
        cnt             <= '0;
        busy            <= 1'b0;
        abort           <= 1'b1;
        boot_jtag_tck   <= 1'b0;
        boot_jtag_tms   <= 1'b1;
        boot_jtag_trstn <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
`ifdef JTAG_MASTER_TRST_EN
            if (boot_jtag_en && trst_req) begin
              state           <= TRST;
              cnt             <= '0;
              busy            <= 1'b1;
              boot_jtag_tck   <= 1'b0;
              boot_jtag_tms   <= 1'b1;
              boot_jtag_trstn <= 1'b0;
            end else
`endif
            if (boot_jtag_en && start) begin
              tdo_vec <= '0;
              len_q   <= len_clamped;
              tms_q   <= tms_vec;
              tdi_q   <= tdi_vec;
              idx     <= '0;
              cnt     <= '0;
              if (len_clamped == '0) begin
                done <= 1'b1;
              end else begin
                state         <= TLOW;
                busy          <= 1'b1;
                boot_jtag_tck <= 1'b0;
                boot_jtag_tms <= tms_vec[0];
                boot_jtag_tdi <= tdi_vec[0];
              end
            end
          end
          TLOW: begin
            if (cnt == DIV_LAST) begin
              cnt           <= '0;
              state         <= THIGH;
              boot_jtag_tck <= 1'b1;
              tdo_vec       <= tdo_vec | tdo_bit;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          THIGH: begin
            if (cnt == DIV_LAST) begin
              cnt           <= '0;
              boot_jtag_tck <= 1'b0;
              if (idx == len_q - LEN_W'(1)) begin
                state <= FIN;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state         <= TLOW;
                idx           <= idx + LEN_W'(1);
                tms_q         <= tms_nxt;
                tdi_q         <= tdi_nxt;
                boot_jtag_tms <= tms_nxt[0];
                boot_jtag_tdi <= tdi_nxt[0];
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`ifdef JTAG_MASTER_TRST_EN
          TRST: begin
            if (cnt == TRST_LAST) begin
              cnt             <= '0;
              state           <= FIN;
              done            <= 1'b1;
              busy            <= 1'b0;
              boot_jtag_trstn <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`endif
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_soc_fpga_intf_jtag_master.sv
// Directed bench for soc_fpga_intf_jtag_master (DATA_W=8, LEN_W=4, CLK_DIV=2).
// Cycle n of a transaction is the n-th falling edge after the edge that accepts START.
module tb_soc_fpga_intf_jtag_master;

  localparam int DATA_W      = 8;
  localparam int LEN_W       = 4;
  localparam int CLK_DIV     = 2;
  localparam int TRST_CYCLES = 8;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              start;
  logic              trst_req;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] tms_vec;
  logic [DATA_W-1:0] tdi_vec;
  logic [DATA_W-1:0] tdo_vec;
  logic              busy;
  logic              done;
  logic              abort;
  logic              tck;
  logic              tms_o;
  logic              tdi_o;
  logic              tdo;
  logic              trstn;
  logic              loop_en;
  logic              tdo_drv;

  int checks = 0;
  int errors = 0;

  int   rises, tms_match, busy_first, busy_last, busy_cnt;
  int   done_cycle, done_cnt, abort_cycle, abort_cnt, trst_low, timeout;
  logic tms_at_done, abort_tck, abort_tms, abort_busy;

  soc_fpga_intf_jtag_master #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV), .TRST_CYCLES(TRST_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .boot_jtag_en(en), .start(start), .trst_req(trst_req),
    .len(len), .tms_vec(tms_vec), .tdi_vec(tdi_vec), .tdo_vec(tdo_vec),
    .busy(busy), .done(done), .abort(abort),
    .boot_jtag_tck(tck), .boot_jtag_tms(tms_o), .boot_jtag_tdi(tdi_o),
    .boot_jtag_tdo(tdo), .boot_jtag_trstn(trstn)
  );

  assign tdo = loop_en ? tdi_o : tdo_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and observe it on falling edges until DONE/ABORT plus a few cycles.
  task automatic run_txn(input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] tmsv,
                         input logic [DATA_W-1:0] tdiv, input bit hold,
                         input int abort_rise, input int budget);
    logic prev_tck;
    int   stop_at;
    rises = 0; tms_match = 0; busy_first = 0; busy_last = 0; busy_cnt = 0;
    done_cycle = 0; done_cnt = 0; abort_cycle = 0; abort_cnt = 0; trst_low = 0;
    timeout = 1; tms_at_done = 1'bx; abort_tck = 1'bx; abort_tms = 1'bx; abort_busy = 1'bx;
    stop_at  = budget;
    prev_tck = tck;
    len = l; tms_vec = tmsv; tdi_vec = tdiv; start = 1'b1;
    @(posedge clk);
    #1;
    trst_req = 1'b0;
    if (!hold) start = 1'b0;
    for (int n = 1; n <= stop_at; n++) begin
      @(negedge clk);
      if (tck && !prev_tck) begin
        rises++;
        if (rises <= DATA_W && tms_o === tmsv[rises-1]) tms_match++;
        if (rises == abort_rise) en = 1'b0;
      end
      prev_tck = tck;
      if (busy) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = n;
        busy_last = n;
      end
      if (!trstn) trst_low++;
      if (done) begin
        done_cnt++;
        if (done_cycle == 0) begin
          done_cycle = n; tms_at_done = tms_o; start = 1'b0; timeout = 0; stop_at = n + 4;
        end
      end
      if (abort) begin
        abort_cnt++;
        if (abort_cycle == 0) begin
          abort_cycle = n; abort_tck = tck; abort_tms = tms_o; abort_busy = busy;
          timeout = 0; stop_at = n + 4;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; trst_req = 1'b0; len = '0;
    tms_vec = '0; tdi_vec = '0; loop_en = 1'b0; tdo_drv = 1'b0;

    $display("[TB] reset held with toggling inputs");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      en = 1'($urandom); start = 1'($urandom); trst_req = 1'($urandom);
      len = LEN_W'($urandom); tms_vec = DATA_W'($urandom); tdi_vec = DATA_W'($urandom);
      tdo_drv = 1'($urandom);
    end
    @(negedge clk);
    check("rst_tck", tck, 0);
    check("rst_tms", tms_o, 1);
    check("rst_tdi", tdi_o, 0);
    check("rst_trstn", trstn, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_abort", abort, 0);
    check("rst_tdo_vec", tdo_vec, 0);
    en = 1'b0; start = 1'b0; trst_req = 1'b0; tdo_drv = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);

    $display("[TB] LEN=5 TMS=1F");
    run_txn(4'd5, 8'h1F, 8'h00, 1'b0, 0, 200);
    check("l5_timeout", timeout, 0);
    check("l5_rises", rises, 5);
    check("l5_tms_at_rise", tms_match, 5);
    check("l5_done_cycle", done_cycle, 21);
    check("l5_done_cnt", done_cnt, 1);
    check("l5_busy_first", busy_first, 1);
    check("l5_busy_last", busy_last, 20);
    check("l5_busy_cnt", busy_cnt, 20);
    check("l5_abort_cnt", abort_cnt, 0);
    check("l5_trstn", trst_low, 0);
    check("l5_tdo_vec", tdo_vec, 8'h00);
    check("l5_tms_hold", tms_at_done, 1);

    $display("[TB] loopback LEN=8 TDI=A5 and LEN=3 TDI=FF");
    loop_en = 1'b1;
    run_txn(4'd8, 8'h00, 8'hA5, 1'b0, 0, 200);
    check("l8_done_cycle", done_cycle, 33);
    check("l8_rises", rises, 8);
    check("l8_tdo_vec", tdo_vec, 8'hA5);
    run_txn(4'd3, 8'h00, 8'hFF, 1'b0, 0, 200);
    check("l3_done_cycle", done_cycle, 13);
    check("l3_tdo_vec", tdo_vec, 8'h07);
    repeat (5) @(negedge clk);
    check("l3_tdo_hold", tdo_vec, 8'h07);

    $display("[TB] LEN=0 and LEN=15 clamp with START held");
    run_txn(4'd0, 8'hFF, 8'hFF, 1'b0, 0, 50);
    check("l0_done_cycle", done_cycle, 1);
    check("l0_rises", rises, 0);
    check("l0_busy_cnt", busy_cnt, 0);
    check("l0_tdo_vec", tdo_vec, 8'h00);
    run_txn(4'd15, 8'h16, 8'h3C, 1'b1, 0, 200);
    check("l15_rises", rises, 8);
    check("l15_tms_at_rise", tms_match, 8);
    check("l15_done_cycle", done_cycle, 33);
    check("l15_done_cnt", done_cnt, 1);
    check("l15_tdo_vec", tdo_vec, 8'h3C);
    check("l15_tms_hold", tms_at_done, 0);

    $display("[TB] EN dropped after third TCK rise");
    run_txn(4'd8, 8'h00, 8'hFF, 1'b0, 3, 200);
    check("ab_cycle", abort_cycle, 12);
    check("ab_cnt", abort_cnt, 1);
    check("ab_tck", abort_tck, 0);
    check("ab_tms", abort_tms, 1);
    check("ab_busy", abort_busy, 0);
    check("ab_done_cnt", done_cnt, 0);
    check("ab_rises", rises, 3);
    check("ab_tdo_vec", tdo_vec, 8'h07);

    $display("[TB] START with EN low in IDLE");
    run_txn(4'd4, 8'h00, 8'hFF, 1'b0, 0, 10);
    check("dis_busy_cnt", busy_cnt, 0);
    check("dis_done_cnt", done_cnt, 0);
    check("dis_rises", rises, 0);
    check("dis_tdo_vec", tdo_vec, 8'h07);
    en = 1'b1;
    @(negedge clk);

    $display("[TB] TRST_REQ together with START");
    trst_req = 1'b1;
    run_txn(4'd4, 8'h00, 8'hFF, 1'b0, 0, 60);
`ifdef JTAG_MASTER_TRST_EN
    check("tr_trst_low", trst_low, 8);
    check("tr_rises", rises, 0);
    check("tr_done_cycle", done_cycle, 9);
    check("tr_busy_cnt", busy_cnt, 8);
    check("tr_tdo_vec", tdo_vec, 8'h07);
`else
    check("tr_trst_low", trst_low, 0);
    check("tr_rises", rises, 4);
    check("tr_done_cycle", done_cycle, 17);
    check("tr_tdo_vec", tdo_vec, 8'h0F);
`endif

    $display("[TB] reset asserted mid-transaction");
    len = 4'd8; tdi_vec = 8'hFF; tms_vec = 8'h00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_tdo_vec", tdo_vec, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tck", tck, 0);
    check("mid_rst_tms", tms_o, 1);
    check("mid_rst_tdo_vec", tdo_vec, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
